// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle sequencer for the 64-bit register-file/ALU datapath.
// It accepts one RV64 R-type instruction through a valid/ready handshake. It then steps
// the datapath through DECODE, EXECUTE and WRITEBACK, and reports completion with the
// captured ALU zero flag.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-low reset
//   instr_valid/instr  instruction offer (32-bit RV64 word)
//   instr_ready        high only in IDLE (registered)
//   zero_flag          ALU zero result, sampled on the EXECUTE->WRITEBACK edge
//   reg_read_1/2       rs1/rs2 addresses, zero-extended to ADDR_W
//   reg_write          rd address, zero-extended to ADDR_W
//   reg_write_cmd      register-file write enable (WRITEBACK, legal, rd != 0)
//   alu_control        ALU operation code
//   done               one-cycle completion pulse (WRITEBACK)
//   done_zero          captured zero flag, valid with done
//   done_illegal       instruction was not a legal R-type, valid with done
//   retired_count      legal instructions completed (wraps)
module datapath_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] reg_read_1,
  output logic [ADDR_W-1:0] reg_read_2,
  output logic [ADDR_W-1:0] reg_write,
  output logic              reg_write_cmd,
  output logic [7:0]        alu_control,
  output logic              done,
  output logic              done_zero,
  output logic              done_illegal,
  output logic [CNT_W-1:0]  retired_count
);

  typedef enum logic [1:0] {StIdle, StDecode, StExecute, StWriteback} state_e;

  state_e state_q, state_d;

  logic              ready_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [7:0]        alu_q;
  logic              legal_q;
  logic              write_cmd_q;
  logic              done_q;
  logic              done_zero_q;
  logic              done_illegal_q;
  logic [CNT_W-1:0]  count_q;

  logic [7:0] dec_alu;
  logic       dec_legal;
  logic       accept;

  // Decode is done straight off the incoming word, so the registered addresses and
  // operation code are already valid in the DECODE cycle.
  always_comb begin
    dec_alu   = 8'h00;
    dec_legal = 1'b0;
    if (instr[6:0] == 7'h33) begin
      case ({instr[31:25], instr[14:12]})
        {7'h00, 3'd0}: begin dec_alu = 8'h00; dec_legal = 1'b1; end  // ADD
        {7'h20, 3'd0}: begin dec_alu = 8'h01; dec_legal = 1'b1; end  // SUB
        {7'h00, 3'd1}: begin dec_alu = 8'h02; dec_legal = 1'b1; end  // SLL
        {7'h00, 3'd2}: begin dec_alu = 8'h03; dec_legal = 1'b1; end  // SLT
        {7'h00, 3'd3}: begin dec_alu = 8'h04; dec_legal = 1'b1; end  // SLTU
        {7'h00, 3'd4}: begin dec_alu = 8'h05; dec_legal = 1'b1; end  // XOR
        {7'h00, 3'd5}: begin dec_alu = 8'h06; dec_legal = 1'b1; end  // SRL
        {7'h20, 3'd5}: begin dec_alu = 8'h07; dec_legal = 1'b1; end  // SRA
        {7'h00, 3'd6}: begin dec_alu = 8'h08; dec_legal = 1'b1; end  // OR
        {7'h00, 3'd7}: begin dec_alu = 8'h09; dec_legal = 1'b1; end  // AND
        default:       begin dec_alu = 8'h00; dec_legal = 1'b0; end
      endcase
    end
  end

  // ready_q stays low through the cycle following a reset edge, so the state check
  // alone is not enough to gate the handshake.
  assign accept = (state_q == StIdle) && ready_q && instr_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (accept) state_d = StDecode;
      StDecode:    state_d = legal_q ? StExecute : StWriteback;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= StIdle;
      ready_q        <= 1'b0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      alu_q          <= 8'h00;
      legal_q        <= 1'b0;
      write_cmd_q    <= 1'b0;
      done_q         <= 1'b0;
      done_zero_q    <= 1'b0;
      done_illegal_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StIdle);
      if (accept) begin
        rs1_q   <= ADDR_W'(instr[19:15]);
        rs2_q   <= ADDR_W'(instr[24:20]);
        rd_q    <= ADDR_W'(instr[11:7]);
        alu_q   <= dec_alu;
        legal_q <= dec_legal;
      end
      // Completion outputs are set on the edge into WRITEBACK and cleared on the way out.
      write_cmd_q    <= (state_d == StWriteback) && legal_q && (rd_q != '0);
      done_q         <= (state_d == StWriteback);
      done_illegal_q <= (state_d == StWriteback) && !legal_q;
      // Only the EXECUTE->WRITEBACK edge samples zero_flag; illegal ones skip EXECUTE.
      done_zero_q    <= (state_q == StExecute) ? zero_flag : 1'b0;
      if ((state_q == StWriteback) && legal_q) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign instr_ready   = ready_q;
  assign reg_read_1    = rs1_q;
  assign reg_read_2    = rs2_q;
  assign reg_write     = rd_q;
  assign alu_control   = alu_q;
  assign reg_write_cmd = write_cmd_q;
  assign done          = done_q;
  assign done_zero     = done_zero_q;
  assign done_illegal  = done_illegal_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed bench for datapath_ctrl with a completion scoreboard.
// A second instance with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_datapath_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        zero_flag;
  logic        instr_ready;
  logic [7:0]  reg_read_1, reg_read_2, reg_write, alu_control;
  logic        reg_write_cmd, done, done_zero, done_illegal;
  logic [15:0] retired_count;

  logic        w_ready, w_write_cmd, w_done, w_zero, w_illegal;
  logic [7:0]  w_rd1, w_rd2, w_wr, w_alu;
  logic [1:0]  w_count;

  always #5 clock = ~clock;

  datapath_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .zero_flag     (zero_flag),
    .reg_read_1    (reg_read_1),
    .reg_read_2    (reg_read_2),
    .reg_write     (reg_write),
    .reg_write_cmd (reg_write_cmd),
    .alu_control   (alu_control),
    .done          (done),
    .done_zero     (done_zero),
    .done_illegal  (done_illegal),
    .retired_count (retired_count)
  );

  datapath_ctrl #(.ADDR_W(8), .CNT_W(2)) dut_w (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (w_ready),
    .zero_flag     (zero_flag),
    .reg_read_1    (w_rd1),
    .reg_read_2    (w_rd2),
    .reg_write     (w_wr),
    .reg_write_cmd (w_write_cmd),
    .alu_control   (w_alu),
    .done          (w_done),
    .done_zero     (w_zero),
    .done_illegal  (w_illegal),
    .retired_count (w_count)
  );

  typedef struct packed {
    logic       illegal;
    logic       zero;
    logic       wr;
    logic [7:0] rd;
    logic [7:0] alu;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [15:0] exp_count = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every done pulse must match the oldest accepted instruction.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_alu",      {24'h0, alu_control}, {24'h0, e.alu});
        check("sb_write",    {31'h0, reg_write_cmd}, {31'h0, e.wr});
        check("sb_rd",       {24'h0, reg_write}, {24'h0, e.rd});
        check("sb_zero",     {31'h0, done_zero}, {31'h0, e.zero});
        check("sb_illegal",  {31'h0, done_illegal}, {31'h0, e.illegal});
        check("sb_w_done",   {31'h0, w_done}, 32'd1);
        check("sb_w_alu",    {24'h0, w_alu}, {24'h0, e.alu});
      end
    end
  end

  // Starts and ends at the falling edge of an IDLE cycle.
  task automatic run_instr(input logic [31:0] ins, input logic zf, input logic legal,
                           input logic [7:0] alu);
    exp_t e;
    logic [7:0] rd, rs1, rs2;
    rd  = {3'b000, ins[11:7]};
    rs1 = {3'b000, ins[19:15]};
    rs2 = {3'b000, ins[24:20]};
    e.illegal = !legal;
    e.zero    = legal & zf;
    e.wr      = legal && (rd != 8'h00);
    e.rd      = rd;
    e.alu     = legal ? alu : 8'h00;

    check("ready_idle", {31'h0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    zero_flag   = ~zf;
    @(posedge clock);
    sb.push_back(e);
    #1;
    instr_valid = 1'b0;
    instr       = ~ins;
    zero_flag   = ~zf;
    @(negedge clock);
    check("decode_rs1",   {24'h0, reg_read_1}, {24'h0, rs1});
    check("decode_rs2",   {24'h0, reg_read_2}, {24'h0, rs2});
    check("decode_rd",    {24'h0, reg_write}, {24'h0, rd});
    check("decode_ready", {31'h0, instr_ready}, 32'd0);
    check("decode_done",  {31'h0, done}, 32'd0);
    if (legal) begin
      @(posedge clock);
      #1 zero_flag = zf;
      @(negedge clock);
      check("exec_alu",   {24'h0, alu_control}, {24'h0, alu});
      check("exec_ready", {31'h0, instr_ready}, 32'd0);
      check("exec_done",  {31'h0, done}, 32'd0);
      check("exec_write", {31'h0, reg_write_cmd}, 32'd0);
    end
    @(posedge clock);
    #1 zero_flag = ~zf;
    @(negedge clock);
    check("wb_done",  {31'h0, done}, 32'd1);
    check("wb_write", {31'h0, reg_write_cmd}, {31'h0, e.wr});
    check("wb_ready", {31'h0, instr_ready}, 32'd0);
    check("wb_rs1",   {24'h0, reg_read_1}, {24'h0, rs1});
    @(posedge clock);
    #1;
    @(negedge clock);
    if (legal) exp_count = exp_count + 16'd1;
    check("idle_ready",   {31'h0, instr_ready}, 32'd1);
    check("idle_done",    {31'h0, done}, 32'd0);
    check("idle_write",   {31'h0, reg_write_cmd}, 32'd0);
    check("idle_rd_hold", {24'h0, reg_write}, {24'h0, rd});
    check("count",        {16'h0, retired_count}, {16'h0, exp_count});
    check("count_wrap",   {30'h0, w_count}, {30'h0, exp_count[1:0]});
  endtask

  initial begin
    exp_t e;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    zero_flag   = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", {31'h0, instr_ready}, 32'd0);
    check("rst_rs1",   {24'h0, reg_read_1}, 32'd0);
    check("rst_rs2",   {24'h0, reg_read_2}, 32'd0);
    check("rst_rd",    {24'h0, reg_write}, 32'd0);
    check("rst_alu",   {24'h0, alu_control}, 32'd0);
    check("rst_write", {31'h0, reg_write_cmd}, 32'd0);
    check("rst_done",  {29'h0, done, done_zero, done_illegal}, 32'd0);
    check("rst_count", {16'h0, retired_count}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);

    run_instr(32'h002081B3, 1'b0, 1'b1, 8'h00);  // add  x3,x1,x2
    run_instr(32'h407302B3, 1'b1, 1'b1, 8'h01);  // sub  x5,x6,x7, zero in EXECUTE
    run_instr(32'h0020F033, 1'b1, 1'b1, 8'h09);  // and  x0,x1,x2, no write
    run_instr(32'h00100093, 1'b1, 1'b0, 8'h00);  // addi: illegal
    run_instr(32'h4020F1B3, 1'b0, 1'b0, 8'h00);  // funct7 0x20 with AND: illegal
    run_instr(32'h002081B2, 1'b1, 1'b0, 8'h00);  // add fields, wrong opcode: illegal
    run_instr(32'h40C5D533, 1'b0, 1'b1, 8'h07);  // sra  x10,x11,x12 (2-bit counter wraps)
    run_instr(32'h003130B3, 1'b1, 1'b1, 8'h04);  // sltu x1,x2,x3

    // Back-to-back: valid held high, accepts land every 4 cycles.
    instr       = 32'h0062E233;  // or x4,x5,x6
    instr_valid = 1'b1;
    zero_flag   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("b2b_ready", {31'h0, instr_ready}, {31'h0, (i % 4) == 0});
      check("b2b_done",  {31'h0, done}, {31'h0, (i % 4) == 3});
      if ((i % 4) == 0) begin
        e.illegal = 1'b0;
        e.zero    = 1'b0;
        e.wr      = 1'b1;
        e.rd      = 8'd4;
        e.alu     = 8'h08;
        sb.push_back(e);
      end
      @(posedge clock);
      #1;
      if (i == 8) instr_valid = 1'b0;
      @(negedge clock);
    end
    exp_count = exp_count + 16'd3;
    check("b2b_count",      {16'h0, retired_count}, {16'h0, exp_count});
    check("b2b_count_wrap", {30'h0, w_count}, {30'h0, exp_count[1:0]});

    // Reset during EXECUTE: the instruction is abandoned, nothing pushed.
    instr       = 32'h009443B3;  // xor x7,x8,x9
    instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(negedge clock);
    check("abort_decode_ready", {31'h0, instr_ready}, 32'd0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    zero_flag = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    exp_count = 16'h0000;
    check("abort_ready", {31'h0, instr_ready}, 32'd0);
    check("abort_addr",  {reg_read_1, reg_read_2, reg_write, alu_control}, 32'd0);
    check("abort_flags", {28'h0, reg_write_cmd, done, done_zero, done_illegal}, 32'd0);
    check("abort_count", {16'h0, retired_count}, {16'h0, exp_count});
    @(posedge clock);
    #1;
    @(negedge clock);
    check("abort_done_after", {31'h0, done}, 32'd0);

    run_instr(32'h0041A133, 1'b0, 1'b1, 8'h03);  // slt x2,x3,x4

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
